// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in / serial-out serializer.
//   state_t             : controller states (IDLE, SHIFT)
//   PISO_DEFAULT_WIDTH  : default parallel word width
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int PISO_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the serializer.
// Counts transferred bits of the current word and flags the last position.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : return count to 0 (has priority over inc)
//   inc        : advance count by one
//   cnt        : current bit position within the word
//   tc         : terminal count, high when cnt == WIDTH-1
module piso_bit_counter
   import piso_pkg::*;
#(
   parameter int WIDTH = PISO_DEFAULT_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     inc,
   output logic [$clog2(WIDTH)-1:0] cnt,
   output logic                     tc
);

   localparam int CW = $clog2(WIDTH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tc = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer with a one-entry hold buffer so that
// consecutive words stream with no gap between them.
// States:
//   state | meaning
//   IDLE  | nothing to send, waiting for a word
//   SHIFT | shift register holds the word being sent, serial_valid high
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   parallel_in   : word to serialize, qualified by load_valid
//   load_valid    : parallel_in is valid
//   load_ready    : a word can be accepted this cycle (hold buffer empty)
//   serial_out    : current serial bit (0 when not valid)
//   serial_valid  : serial_out carries a bit
//   serial_ready  : downstream takes the bit this cycle
//   frame_start   : current bit is the first of a word
//   frame_end     : current bit is the last of a word
//   word_done     : one-cycle pulse after the last bit of a word transfers
//   busy          : a word is shifting or buffered
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH     = PISO_DEFAULT_WIDTH,
   parameter int LSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] parallel_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             serial_out,
   output logic             serial_valid,
   input  logic             serial_ready,
   output logic             frame_start,
   output logic             frame_end,
   output logic             word_done,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_next;
   logic [WIDTH-1:0] buf_q;
   logic             buf_full;
   logic [CW-1:0]    cnt;
   logic             last_bit;
   logic             accept;
   logic             xfer;
   logic             cnt_clear;
   logic             cnt_inc;

   assign load_ready   = !buf_full;
   assign serial_valid = (state == SHIFT);
   assign accept       = load_valid & load_ready;
   assign xfer         = serial_valid & serial_ready;

   // Counter restarts whenever a fresh word lands in the shift register.
   assign cnt_clear = ((state == IDLE) & accept) | (xfer & last_bit);
   assign cnt_inc   = xfer & !last_bit;

   piso_bit_counter #(
      .WIDTH (WIDTH)
   ) u_bit_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (cnt_clear),
      .inc   (cnt_inc),
      .cnt   (cnt),
      .tc    (last_bit)
   );

   // Shift toward whichever end feeds serial_out.
   always_comb begin
      shreg_next = shreg;
      if (LSB_FIRST != 0) begin
         shreg_next = {1'b0, shreg[WIDTH-1:1]};
      end else begin
         shreg_next = {shreg[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shreg     <= '0;
         buf_q     <= '0;
         buf_full  <= 1'b0;
         word_done <= 1'b0;
      end else begin
         word_done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  shreg <= parallel_in;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (xfer && last_bit) begin
                  word_done <= 1'b1;
                  // A buffered word blocks accept (load_ready low), so the
                  // direct-load branch only fires with the buffer empty.
                  if (buf_full) begin
                     shreg    <= buf_q;
                     buf_full <= 1'b0;
                  end else if (accept) begin
                     shreg <= parallel_in;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  if (xfer) begin
                     shreg <= shreg_next;
                  end
                  if (accept) begin
                     buf_q    <= parallel_in;
                     buf_full <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      serial_out = 1'b0;
      if (serial_valid) begin
         serial_out = (LSB_FIRST != 0) ? shreg[0] : shreg[WIDTH-1];
      end
   end

   assign frame_start = (state == SHIFT) & (cnt == '0);
   assign frame_end   = (state == SHIFT) & last_bit;
   assign busy        = (state == SHIFT) | buf_full;

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] pin = 4'h0;
   logic       lv = 1'b0;
   logic       sr = 1'b0;

   logic lr_l, so_l, sv_l, fs_l, fe_l, wd_l, busy_l;
   logic lr_m, so_m, sv_m, fs_m, fe_m, wd_m, busy_m;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: queue of words still owing bits, and the position
   // of the next bit within the front word.
   logic [3:0] wq[$];
   int         idx = 0;
   logic       exp_wd = 1'b0;

   int          vcount, rlow, wdcount;
   logic [15:0] gl, gm;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(4), .LSB_FIRST(1)) u_lsb (
      .clk(clk), .rst_n(rst_n), .parallel_in(pin), .load_valid(lv),
      .load_ready(lr_l), .serial_out(so_l), .serial_valid(sv_l),
      .serial_ready(sr), .frame_start(fs_l), .frame_end(fe_l),
      .word_done(wd_l), .busy(busy_l));

   piso_serializer #(.WIDTH(4), .LSB_FIRST(0)) u_msb (
      .clk(clk), .rst_n(rst_n), .parallel_in(pin), .load_valid(lv),
      .load_ready(lr_m), .serial_out(so_m), .serial_valid(sv_m),
      .serial_ready(sr), .frame_start(fs_m), .frame_end(fe_m),
      .word_done(wd_m), .busy(busy_m));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic check_outputs();
      bit         has;
      logic [3:0] front;
      has   = (wq.size() > 0);
      front = has ? wq[0] : 4'h0;
      chk("lsb.serial_valid", {31'd0, sv_l}, {31'd0, has});
      chk("lsb.serial_out",   {31'd0, so_l}, {31'd0, has ? front[idx] : 1'b0});
      chk("lsb.frame_start",  {31'd0, fs_l}, {31'd0, has && idx == 0});
      chk("lsb.frame_end",    {31'd0, fe_l}, {31'd0, has && idx == 3});
      chk("lsb.busy",         {31'd0, busy_l}, {31'd0, has});
      chk("lsb.load_ready",   {31'd0, lr_l}, {31'd0, wq.size() < 2});
      chk("lsb.word_done",    {31'd0, wd_l}, {31'd0, exp_wd});
      chk("msb.serial_valid", {31'd0, sv_m}, {31'd0, has});
      chk("msb.serial_out",   {31'd0, so_m}, {31'd0, has ? front[3-idx] : 1'b0});
      chk("msb.frame_start",  {31'd0, fs_m}, {31'd0, has && idx == 0});
      chk("msb.frame_end",    {31'd0, fe_m}, {31'd0, has && idx == 3});
      chk("msb.busy",         {31'd0, busy_m}, {31'd0, has});
      chk("msb.load_ready",   {31'd0, lr_m}, {31'd0, wq.size() < 2});
      chk("msb.word_done",    {31'd0, wd_m}, {31'd0, exp_wd});
   endtask

   task automatic step(input logic l, input logic [3:0] p, input logic s);
      bit acc, xf;
      @(negedge clk);
      lv = l; pin = p; sr = s;
      #1;
      check_outputs();
      if (sv_l) vcount++;
      if (!lr_l) rlow++;
      if (wd_l) wdcount++;
      if (sv_l && s) begin
         gl = {gl[14:0], so_l};
         gm = {gm[14:0], so_m};
      end
      acc = l && (wq.size() < 2) && rst_n;
      xf  = s && (wq.size() > 0);
      @(posedge clk);
      exp_wd = xf && (idx == 3);
      if (xf) begin
         if (idx == 3) begin
            void'(wq.pop_front());
            idx = 0;
         end else begin
            idx++;
         end
      end
      if (acc) wq.push_back(p);
   endtask

   task automatic clear_stats();
      vcount = 0; rlow = 0; wdcount = 0; gl = '0; gm = '0;
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b1);
   endtask

   initial begin
      // Reset state, checked before any clock edge.
      #1;
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      idle_steps(2);

      // 0110, ready always high.
      clear_stats();
      step(1'b1, 4'b0110, 1'b1);
      idle_steps(6);
      chk("s1.lsb_bits", {28'd0, gl[3:0]}, 32'h6);
      chk("s1.msb_bits", {28'd0, gm[3:0]}, 32'h6);
      chk("s1.valid_cycles", vcount, 4);
      chk("s1.word_done_cnt", wdcount, 1);

      // 1100: MSB-first gives 1,1,0,0.
      clear_stats();
      step(1'b1, 4'b1100, 1'b1);
      idle_steps(6);
      chk("s2.msb_bits", {28'd0, gm[3:0]}, 32'hC);
      chk("s2.lsb_bits", {28'd0, gl[3:0]}, 32'h3);

      // Back-to-back 0101 then 1001.
      clear_stats();
      step(1'b1, 4'b0101, 1'b1);
      step(1'b1, 4'b1001, 1'b1);
      idle_steps(10);
      chk("s3.lsb_bits", {24'd0, gl[7:0]}, 32'hA9);
      chk("s3.msb_bits", {24'd0, gm[7:0]}, 32'h59);
      chk("s3.valid_cycles", vcount, 8);
      chk("s3.ready_low_cycles", rlow, 3);
      chk("s3.word_done_cnt", wdcount, 2);

      // Stall three cycles at bit 2 of 0011.
      clear_stats();
      step(1'b1, 4'b0011, 1'b1);
      step(1'b0, 4'h0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b0);
      idle_steps(5);
      chk("s4.lsb_bits", {28'd0, gl[3:0]}, 32'hC);
      chk("s4.frame_cycles", vcount, 7);
      chk("s4.word_done_cnt", wdcount, 1);

      // Reset at bit 3 with a word buffered.
      clear_stats();
      step(1'b1, 4'b0101, 1'b1);
      step(1'b1, 4'b1010, 1'b1);
      step(1'b0, 4'h0, 1'b1);
      @(negedge clk);
      rst_n = 1'b0; lv = 1'b0;
      #1;
      wq.delete(); idx = 0; exp_wd = 1'b0;
      check_outputs();
      step(1'b0, 4'h0, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      idle_steps(1);
      clear_stats();
      step(1'b1, 4'b1111, 1'b1);
      idle_steps(6);
      chk("s5.lsb_bits", {24'd0, gl[7:0]}, 32'h0F);
      chk("s5.valid_cycles", vcount, 4);
      chk("s5.word_done_cnt", wdcount, 1);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 3) != 0));
      end
      idle_steps(12);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the parallel word width in bits (minimum 2).
REQ-002 SHALL have parameter LSB_FIRST, default 1; 1 = LSB shifted first, 0 = MSB shifted first.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port parallel_in  input  WIDTH  word to serialize (adder result).
REQ-007 SHALL have port load_valid  input  1  parallel_in is valid.
REQ-008 SHALL have port load_ready  output  1  block can accept a word this cycle.
REQ-009 SHALL have port serial_out  output  1  current serial bit.
REQ-010 SHALL have port serial_valid  output  1  serial_out carries a valid bit.
REQ-011 SHALL have port serial_ready  input  1  downstream consumes the bit this cycle.
REQ-012 SHALL have port frame_start  output  1  current bit is the first bit of a word.
REQ-013 SHALL have port frame_end  output  1  current bit is the last bit of a word.
REQ-014 SHALL have port word_done  output  1  registered one-cycle pulse after the last bit of a word transfers.
REQ-015 SHALL have port busy  output  1  a word is shifting or buffered.

Function
REQ-016 SHALL define accept = load_valid & load_ready and xfer = serial_valid & serial_ready.
REQ-017 SHALL drive load_ready = !buf_full combinationally, where buf_full flags a one-entry hold buffer.
REQ-018 SHALL implement the FSM states IDLE and SHIFT, plus a shift register, a hold buffer and a bit counter cnt of width clog2(WIDTH).
REQ-019 In IDLE, accept SHALL load parallel_in into the shift register, clear cnt and enter SHIFT; serial_valid is then high on the next cycle (latency 1).
REQ-020 In SHIFT, serial_valid SHALL be 1 and serial_out SHALL equal shreg[0] when LSB_FIRST=1, or shreg[WIDTH-1] when LSB_FIRST=0.
REQ-021 In SHIFT, xfer with cnt<WIDTH-1 SHALL shift one position toward the output and increment cnt; without xfer, all state SHALL hold (stall).
REQ-022 In SHIFT, xfer with cnt==WIDTH-1 (last bit) SHALL:
- if buf_full: load the buffer into the shift register, clear buf_full, clear cnt and stay in SHIFT;
- else if accept: load parallel_in directly, clear cnt and stay in SHIFT;
- else: go to IDLE.
REQ-023 In SHIFT, any accept not covered by REQ-022 SHALL write parallel_in into the hold buffer and set buf_full.
REQ-024 Back-to-back words SHALL serialize with no idle cycle between the last bit of one word and the first bit of the next.
REQ-025 frame_start SHALL be SHIFT & cnt==0, frame_end SHALL be SHIFT & cnt==WIDTH-1, and both SHALL be held during stalls.
REQ-026 busy SHALL be (state==SHIFT) | buf_full.
REQ-027 When serial_valid=0, serial_out SHALL be 0.

Reset
REQ-028 rst_n low SHALL immediately force IDLE and clear the shift register, buffer, buf_full, cnt and word_done, regardless of clk.
REQ-029 During and after reset, SHALL drive serial_out=0, serial_valid=0, frame_start=0, frame_end=0, word_done=0, busy=0 and load_ready=1.
REQ-030 Reset mid-frame SHALL discard the partial word and any buffered word; no word_done SHALL be produced for them.

Structure
REQ-031 Package piso_pkg SHALL hold the state enum (IDLE, SHIFT) and the default width constant (4).
REQ-032 The bit counter with terminal-count flag SHALL be the only sub-module, named piso_bit_counter; everything else SHALL be in piso_serializer.

Verification
REQ-033 Send 4'b0110 with LSB_FIRST=1 and serial_ready=1 -> serial_out 0,1,1,0 on four consecutive cycles starting the cycle after accept; frame_start on bit 1; frame_end on bit 4; word_done the cycle after bit 4.
REQ-034 Send 4'b1100 with LSB_FIRST=0 -> serial_out 1,1,0,0.
REQ-035 Send 4'b0101 then 4'b1001 back-to-back -> 8 contiguous bits 1,0,1,0,1,0,0,1; load_ready low while the buffer is full; two word_done pulses.
REQ-036 Hold serial_ready=0 for 3 cycles at bit 2 of 4'b0011 -> serial_out, cnt and frame flags hold; the sequence resumes unchanged; total frame is 7 cycles.
REQ-037 Assert rst_n=0 at bit 3 with a word buffered -> outputs go to reset values immediately; after release, a new 4'b1111 serializes cleanly with no stale bits.
